dec32_rr_arbiter: RTL

//  Round-robin arbiter sharing one 32-way select resource between 32 requesters.

---
 rtl/dec32_rr_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/dec32_rr_arbiter.sv
// Round-robin arbiter: one 32-way select shared by 32 requesters.
// The grant is registered and driven both as a 5-bit index and as a one-hot vector.
module dec32_rr_arbiter #(
  parameter int N        = 32,
  parameter int IDXW     = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD);
  localparam bit          TO_EN    = (MAX_HOLD != 0);

  state_t          r_state,     w_state_next;
  logic [IDXW-1:0] r_ptr,       w_ptr_next;
  logic [15:0]     r_hold_cnt,  w_hold_cnt_next;
  logic [N-1:0]    r_gnt,       w_gnt_next;
  logic [IDXW-1:0] r_gnt_idx,   w_gnt_idx_next;
  logic            r_gnt_valid, w_gnt_valid_next;
  logic            r_timeout,   w_timeout_next;

  logic [N-1:0]    w_rot;
  logic            w_found;
  logic [IDXW-1:0] w_off;
  logic [IDXW-1:0] w_pick;
  logic            w_release;

  // Rotate requests so bit 0 is the current highest-priority requester.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot[gi] = req[IDXW'(r_ptr + IDXW'(gi))];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDXW'(i);
      end
    end
  end

  assign w_pick = r_ptr + w_off;

  // Hold limit only revokes a grant whose request is still asserted.
  assign w_release = !req[r_gnt_idx] || (TO_EN && (r_hold_cnt == HOLD_LIM));

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_hold_cnt_next  = r_hold_cnt;
    w_gnt_next       = r_gnt;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_valid_next = r_gnt_valid;
    w_timeout_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_gnt_next       = N'(1) << w_pick;
          w_gnt_idx_next   = w_pick;
          w_gnt_valid_next = 1'b1;
          w_hold_cnt_next  = 16'd1;
          w_state_next     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_gnt_next       = '0;
          w_gnt_valid_next = 1'b0;
          w_ptr_next       = r_gnt_idx + IDXW'(1);
          w_timeout_next   = req[r_gnt_idx];
          w_state_next     = S_IDLE;
        end else if (r_hold_cnt != 16'hFFFF) begin
          w_hold_cnt_next  = r_hold_cnt + 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_gnt       <= w_gnt_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
